// File: rtl/uga_uart_rx_param.sv
// uga_uart_rx_param: parametrised UART receiver.
// Glitch-filtered RX line, oversampled bit timing and configurable frame format
// (data width, parity, stop bits). Received frames go into a one-entry valid/ready
// holding register with per-frame parity/frame/break flags and a sticky overrun.
// Optional idle-timeout pulse: define UART_RX_TIMEOUT_EN to build it; otherwise
// rx_timeout is tied low.
module uga_uart_rx_param #(
    parameter int DATA_BITS     = 8,   // payload bits, 5..9, LSB first on the line
    parameter int OVERSAMPLE    = 8,   // ticks per bit period, power of two, 4..16
    parameter int PARITY        = 0,   // 0 = none, 1 = even, 2 = odd
    parameter int STOP_BITS     = 1,   // stop bits checked, 1 or 2
    parameter int FILTER_LEN    = 8,   // equal consecutive samples to move the filtered level
    parameter int TIMEOUT_CHARS = 4    // idle character times before rx_timeout
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rxd,
    input  logic                 rx_enable,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 m_break,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy,
    output logic                 rx_timeout
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Line filter state
    // ------------------------------------------------------------------
    logic [FILTER_LEN-1:0] filt_q;
    logic                  level_q;
    logic                  level_prev_q;
    logic                  fall;

    // ------------------------------------------------------------------
    // Bit timing and frame assembly state
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            bit_cnt_q;
    logic                  stop_cnt_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  par_acc_q;
    logic                  par_bit_q;
    logic                  par_err_q;
    logic                  stop_err_q;

    // ------------------------------------------------------------------
    // Output holding register
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0]  m_data_q;
    logic                  m_valid_q;
    logic                  m_parity_err_q;
    logic                  m_frame_err_q;
    logic                  m_break_q;
    logic                  overrun_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  start_det;
    logic                  sample;
    logic                  par_expect;
    logic                  last_stop;
    logic                  frame_done;
    logic                  stop_err_d;
    logic                  brk_d;
    logic                  accept_d;
    logic                  overrun_set;

    // Filter: level only moves once the whole window agrees, so short glitches vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q       <= '1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
        end else begin
            filt_q       <= {filt_q[FILTER_LEN-2:0], rxd};
            level_prev_q <= level_q;
            if (&filt_q) begin
                level_q <= 1'b1;
            end else if (~|filt_q) begin
                level_q <= 1'b0;
            end
        end
    end

    assign fall      = level_prev_q & ~level_q;
    assign start_det = fall & rx_enable & (state_q == ST_IDLE);
    assign sample    = tick & (cnt_q == CNT_LAST);

    // Sample counter: reload at half a bit on a start edge so samples land mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start_det) begin
            cnt_q <= CNT_MID;
        end else if (tick) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Frame-level decisions evaluated at the last stop sample.
    always_comb begin
        par_expect  = (PARITY == 1) ? par_acc_q : ~par_acc_q;
        last_stop   = (stop_cnt_q == STOP_LAST);
        frame_done  = (state_q == ST_STOP) & sample & last_stop;
        stop_err_d  = stop_err_q | ~level_q;
        // A break is an all-zero character (parity bit included) that also
        // failed its stop check; par_bit_q stays 0 when there is no parity bit.
        brk_d       = (shift_q == '0) & ~par_bit_q & stop_err_d;
        accept_d    = ~m_valid_q | m_ready;
        overrun_set = frame_done & ~accept_d;
    end

    // Receive FSM and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            stop_cnt_q     <= 1'b0;
            shift_q        <= '0;
            par_acc_q      <= 1'b0;
            par_bit_q      <= 1'b0;
            par_err_q      <= 1'b0;
            stop_err_q     <= 1'b0;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            m_parity_err_q <= 1'b0;
            m_frame_err_q  <= 1'b0;
            m_break_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_det) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        if (level_q) begin
                            // Line back high at mid start bit: it was a glitch.
                            state_q <= ST_IDLE;
                        end else begin
                            state_q    <= ST_DATA;
                            bit_cnt_q  <= '0;
                            stop_cnt_q <= 1'b0;
                            par_acc_q  <= 1'b0;
                            par_bit_q  <= 1'b0;
                            par_err_q  <= 1'b0;
                            stop_err_q <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        // LSB arrives first, so shift in at the top.
                        shift_q   <= {level_q, shift_q[DATA_BITS-1:1]};
                        par_acc_q <= par_acc_q ^ level_q;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        par_bit_q <= level_q;
                        par_err_q <= (level_q != par_expect);
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        stop_err_q <= stop_err_d;
                        if (last_stop) begin
                            // Line still low: wait for it to return high before
                            // allowing another start, so a break reports once.
                            state_q <= level_q ? ST_IDLE : ST_BRK_WAIT;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                ST_BRK_WAIT: begin
                    if (level_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Holding register: load on completion if empty or being drained
            // this clk; otherwise the new frame is dropped.
            if (frame_done && accept_d) begin
                m_valid_q      <= 1'b1;
                m_data_q       <= brk_d ? '0 : shift_q;
                m_parity_err_q <= (PARITY != 0) ? par_err_q : 1'b0;
                m_frame_err_q  <= stop_err_d & ~brk_d;
                m_break_q      <= brk_d;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end

            // Sticky overrun; a new drop beats a simultaneous clear.
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_parity_err = m_parity_err_q;
    assign m_frame_err  = m_frame_err_q;
    assign m_break      = m_break_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != ST_IDLE);

`ifdef UART_RX_TIMEOUT_EN
    localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CHARS * FRAME_BITS - 1);

    logic [15:0] idle_cnt_q;
    logic        to_armed_q;
    logic        rx_timeout_q;

    // Idle timer: counts bit periods spent idle after a frame, fires once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q   <= '0;
            to_armed_q   <= 1'b0;
            rx_timeout_q <= 1'b0;
        end else begin
            rx_timeout_q <= 1'b0;
            if (frame_done) begin
                idle_cnt_q <= '0;
                to_armed_q <= 1'b1;
            end else if (fall) begin
                idle_cnt_q <= '0;
            end else if (to_armed_q && (state_q == ST_IDLE) && sample) begin
                if (idle_cnt_q == TO_LAST) begin
                    rx_timeout_q <= 1'b1;
                    to_armed_q   <= 1'b0;
                    idle_cnt_q   <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + 1'b1;
                end
            end
        end
    end

    assign rx_timeout = rx_timeout_q;
`else
    // No idle timer built; the comparison is constant false for any legal count.
    assign rx_timeout = (TIMEOUT_CHARS < 0);
`endif

endmodule

// File: tb/tb_uga_uart_rx_param.sv
// Bench for uga_uart_rx_param: one 8N1 instance (OVERSAMPLE=8) and one
// 7-bit even-parity two-stop instance (OVERSAMPLE=16) on a shared tick.
module tb_uga_uart_rx_param;

    localparam int TICK_CLKS = 4;
    localparam int BIT_A = 8 * TICK_CLKS;
    localparam int BIT_B = 16 * TICK_CLKS;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } rec_t;

    typedef struct {
        logic [6:0] d;
        logic       pbit;
        logic [1:0] stops;      // [0] first stop bit, [1] second
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx_enable = 1'b1;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       m_ready_a = 1'b1, m_ready_b = 1'b1;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] m_data_a;
    logic [6:0] m_data_b;
    logic       m_valid_a, m_valid_b;
    logic       m_parity_err_a, m_parity_err_b;
    logic       m_frame_err_a, m_frame_err_b;
    logic       m_break_a, m_break_b;
    logic       overrun_a, overrun_b;
    logic       busy_a, busy_b;
    logic       rx_timeout_a, rx_timeout_b;

    int   errors = 0;
    int   checks = 0;
    rec_t qa[$];
    rec_t qb[$];
    int   to_pulses_a = 0;
    int   lat_c;
    logic saw;

    uga_uart_rx_param u_a (
        .clk(clk), .rst(rst), .tick(tick), .rxd(rxd_a), .rx_enable(rx_enable),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
        .m_parity_err(m_parity_err_a), .m_frame_err(m_frame_err_a), .m_break(m_break_a),
        .overrun(overrun_a), .clr_overrun(clr_a), .busy(busy_a), .rx_timeout(rx_timeout_a)
    );

    uga_uart_rx_param #(
        .DATA_BITS(7), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2), .FILTER_LEN(8), .TIMEOUT_CHARS(4)
    ) u_b (
        .clk(clk), .rst(rst), .tick(tick), .rxd(rxd_b), .rx_enable(rx_enable),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .m_parity_err(m_parity_err_b), .m_frame_err(m_frame_err_b), .m_break(m_break_b),
        .overrun(overrun_b), .clr_overrun(clr_b), .busy(busy_b), .rx_timeout(rx_timeout_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_CLKS - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Capture every accepted transfer and count timeout pulses.
    always @(negedge clk) begin
        if (!rst && m_valid_a && m_ready_a)
            qa.push_back({9'(m_data_a), m_parity_err_a, m_frame_err_a, m_break_a});
        if (!rst && m_valid_b && m_ready_b)
            qb.push_back({9'(m_data_b), m_parity_err_b, m_frame_err_b, m_break_b});
        if (!rst && rx_timeout_a)
            to_pulses_a++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: what the receiver should report for a given line frame.
    function automatic rec_t model(input logic [8:0] d, input int dbits, input int pmode,
                                   input logic pbit, input logic [1:0] stops, input int nstops);
        rec_t r;
        int   ones = 0;
        logic serr = 1'b0;
        for (int i = 0; i < dbits; i++) ones += int'(d[i]);
        for (int i = 0; i < nstops; i++) if (!stops[i]) serr = 1'b1;
        if (pmode == 1)      r.perr = (pbit != ((ones % 2) == 1));
        else if (pmode == 2) r.perr = (pbit != ((ones % 2) == 0));
        else                 r.perr = 1'b0;
        r.brk  = (d == 9'd0) && (pmode == 0 || pbit == 1'b0) && serr;
        r.ferr = serr && !r.brk;
        r.data = r.brk ? 9'd0 : d;
        return r;
    endfunction

    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stp);
        return {6'd0, stp, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [6:0] d, input logic p, input logic [1:0] st);
        return {5'd0, st[1], st[0], p, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which) rxd_b = bits[i]; else rxd_a = bits[i];
            repeat (which ? BIT_B : BIT_A) @(negedge clk);
        end
        if (which) rxd_b = 1'b1; else rxd_a = 1'b1;
    endtask

    task automatic idle(input bit which, input int nbits);
        repeat (nbits * (which ? BIT_B : BIT_A)) @(negedge clk);
    endtask

    task automatic expect_frame(input string name, input bit which, input rec_t exp);
        rec_t got;
        int   n;
        n = which ? qb.size() : qa.size();
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL %s: frames reported=%0d required=1", name, n);
        end else begin
            got = which ? qb.pop_front() : qa.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got data=%0h perr=%0b ferr=%0b brk=%0b required data=%0h perr=%0b ferr=%0b brk=%0b",
                         name, got.data, got.perr, got.ferr, got.brk, exp.data, exp.perr, exp.ferr, exp.brk);
            end
        end
        if (which) qb.delete(); else qa.delete();
    endtask

    vec_t tbl[7];
    rec_t exp_r;
    int   base;

    initial begin
        // Hand-derived vectors for the 7-bit even-parity, 2-stop instance.
        tbl[0] = '{7'h35, 1'b1, 2'b11, 9'h035, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{7'h35, 1'b0, 2'b11, 9'h035, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{7'h35, 1'b0, 2'b01, 9'h035, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{7'h00, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{7'h7F, 1'b1, 2'b10, 9'h07F, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{7'h01, 1'b0, 2'b11, 9'h001, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{7'h00, 1'b1, 2'b00, 9'h000, 1'b1, 1'b1, 1'b0};

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_a", {m_valid_a, m_data_a, m_parity_err_a, m_frame_err_a, m_break_a,
                          overrun_a, busy_a, rx_timeout_a}, 32'd0);
        check("reset_b", {m_valid_b, m_data_b, m_parity_err_b, m_frame_err_b, m_break_b,
                          overrun_b, busy_b, rx_timeout_b}, 32'd0);
        idle(0, 2);

        // 0xA5 with latency window around the middle of the stop bit.
        fork
            drive(0, frame_a(8'hA5, 1'b1), 10);
            begin
                lat_c = 0;
                while (!m_valid_a && lat_c < 400) begin
                    @(negedge clk);
                    lat_c++;
                end
            end
        join
        check("a5_latency_window", 32'((lat_c >= 300) && (lat_c <= 330)), 32'd1);
        idle(0, 2);
        expect_frame("a5_frame", 0, '{9'h0A5, 1'b0, 1'b0, 1'b0});
        check("a5_busy_after", busy_a, 1'b0);

        // Short glitch must not move the filtered level.
        saw = 1'b0;
        rxd_a = 1'b0;
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2 * BIT_A) begin @(negedge clk); if (busy_a) saw = 1'b1; end
        check("glitch3_no_start", saw, 1'b0);

        // Pulse passes the filter but is gone by mid start bit.
        saw = 1'b0;
        rxd_a = 1'b0;
        repeat (11) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2 * BIT_A) begin @(negedge clk); if (busy_a) saw = 1'b1; end
        check("pulse_started", saw, 1'b1);
        check("pulse_back_idle", busy_a, 1'b0);
        check("pulse_no_frame", qa.size(), 0);

        // Break: line low for two frame times.
        rxd_a = 1'b0;
        repeat (15 * BIT_A) @(negedge clk);
        check("break_brk_wait_busy", busy_a, 1'b1);
        check("break_one_so_far", qa.size(), 1);
        repeat (5 * BIT_A) @(negedge clk);
        rxd_a = 1'b1;
        idle(0, 3);
        check("break_idle_after", busy_a, 1'b0);
        expect_frame("break_frame", 0, '{9'h000, 1'b0, 1'b0, 1'b1});

        // Overrun with consumer stalled.
        m_ready_a = 1'b0;
        drive(0, frame_a(8'h11, 1'b1), 10); idle(0, 2);
        drive(0, frame_a(8'h22, 1'b1), 10); idle(0, 2);
        check("ovr_valid", m_valid_a, 1'b1);
        check("ovr_data_held", m_data_a, 8'h11);
        check("ovr_flag", overrun_a, 1'b1);
        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0; @(negedge clk);
        check("ovr_cleared", overrun_a, 1'b0);
        m_ready_a = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_drained", m_valid_a, 1'b0);
        expect_frame("ovr_frame", 0, '{9'h011, 1'b0, 1'b0, 1'b0});

        // Start detection gated; mid-frame deassert lets the frame finish.
        rx_enable = 1'b0;
        saw = 1'b0;
        fork
            drive(0, frame_a(8'h3C, 1'b1), 10);
            repeat (10 * BIT_A) begin @(negedge clk); if (busy_a) saw = 1'b1; end
        join
        idle(0, 2);
        check("rxen_off_no_start", saw, 1'b0);
        check("rxen_off_no_frame", qa.size(), 0);
        rx_enable = 1'b1;
        fork
            drive(0, frame_a(8'hC3, 1'b1), 10);
            begin repeat (3 * BIT_A) @(negedge clk); rx_enable = 1'b0; end
        join
        idle(0, 2);
        rx_enable = 1'b1;
        expect_frame("rxen_midframe", 0, '{9'h0C3, 1'b0, 1'b0, 1'b0});

        // Table vectors on the parity instance.
        for (int i = 0; i < 7; i++) begin
            drive(1, frame_b(tbl[i].d, tbl[i].pbit, tbl[i].stops), 11);
            idle(1, 3);
            expect_frame($sformatf("tbl_b[%0d]", i), 1,
                         '{tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr, tbl[i].exp_brk});
        end

        // Random frames against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            drive(0, frame_a(d, s), 10);
            idle(0, 3);
            exp_r = model(9'(d), 8, 0, 1'b0, {1'b1, s}, 1);
            expect_frame($sformatf("rand_a[%0d] d=%0h s=%0b", i, d, s), 0, exp_r);
        end
        for (int i = 0; i < 16; i++) begin
            logic [6:0] d;
            logic       p;
            logic [1:0] st;
            d  = 7'($urandom_range(0, 127));
            if (i % 4 == 0) d = 7'd0;
            p  = 1'($urandom_range(0, 1));
            st = 2'($urandom_range(0, 3));
            drive(1, frame_b(d, p, st), 11);
            idle(1, 3);
            exp_r = model(9'(d), 7, 1, p, st, 2);
            expect_frame($sformatf("rand_b[%0d] d=%0h p=%0b st=%0b", i, d, p, st), 1, exp_r);
        end

        // Idle timeout after a frame: 40 bit periods for 8N1, watched for 48.
        drive(0, frame_a(8'h5A, 1'b1), 10);
        base = to_pulses_a;
        idle(0, 48);
`ifdef UART_RX_TIMEOUT_EN
        check("timeout_pulses", to_pulses_a - base, 1);
`else
        check("timeout_pulses", to_pulses_a - base, 0);
`endif
        expect_frame("timeout_frame", 0, '{9'h05A, 1'b0, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
